// File: rtl/adc_sample_avg_if.sv
// ============================================================================
// Module : adc_sample_avg_if
// Brief  : Sample/control/result bundle between an ADC front end and the averager.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface adc_sample_avg_if;
    logic        din_valid;
    logic [15:0] din;
    logic        enable;
    logic        clr;
    logic [15:0] offset;
    logic        avg_valid;
    logic [15:0] avg_out;
    logic        ovr;
    logic        timeout;

    modport master (
        output din_valid, din, enable, clr, offset,
        input  avg_valid, avg_out, ovr, timeout
    );

    modport slave (
        input  din_valid, din, enable, clr, offset,
        output avg_valid, avg_out, ovr, timeout
    );
endinterface

`default_nettype wire

// File: rtl/adc_sample_avg.sv
// ============================================================================
// Module : adc_sample_avg
// Brief  : Edge-qualified ADC sample averager with offset, saturation and gap timeout.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module adc_sample_avg #(
    parameter int AVG_LOG2    = 2,
    parameter int TIMEOUT_CYC = 1000
) (
    input  wire logic        clk_ref,
    input  wire logic        sys_rstn,
    adc_sample_avg_if.slave  bus
);

    localparam int                 c_GAP_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [4:0]         c_WIN_LAST = 5'((1 << AVG_LOG2) - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_MAX  = c_GAP_W'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic                       dv_q;
    logic                       armed_q;
    logic signed [19:0]         acc_q, acc_d;
    logic        [4:0]          cnt_q, cnt_d;
    logic        [c_GAP_W-1:0]  gap_q, gap_d;
    logic                       avg_valid_q, avg_valid_d;
    logic        [15:0]         avg_out_q, avg_out_d;
    logic                       ovr_q, ovr_d;
    logic                       timeout_q, timeout_d;

    logic                       w_edge;
    logic                       w_take;
    logic signed [19:0]         w_sample;
    logic signed [19:0]         w_avg;
    logic signed [20:0]         w_diff;
    logic                       w_sat_hi;
    logic                       w_sat_lo;
    logic        [15:0]         w_res;

    // armed_q blocks a din_valid that is already high when reset releases
    assign w_edge   = bus.din_valid & ~dv_q & armed_q;
    assign w_take   = w_edge & ~bus.clr;
    assign w_sample = {{4{~bus.din[15]}}, ~bus.din[15], bus.din[14:0]};
    assign w_avg    = acc_q >>> AVG_LOG2;
    assign w_diff   = {w_avg[19], w_avg} - {{5{bus.offset[15]}}, bus.offset};
    assign w_sat_hi = (w_diff > 21'sd32767);
    assign w_sat_lo = (w_diff < -21'sd32768);
    assign w_res    = w_sat_hi ? 16'h7FFF : (w_sat_lo ? 16'h8000 : w_diff[15:0]);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        avg_valid_d = 1'b0;
        avg_out_d   = avg_out_q;
        ovr_d       = ovr_q;
        timeout_d   = timeout_q;

        case (state_q)
            IDLE: begin
                acc_d = '0;
                cnt_d = '0;
                gap_d = '0;
                if (bus.enable) state_d = ACCUM;
            end
            ACCUM: begin
                if (!bus.enable) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    gap_d   = '0;
                end else if (w_take) begin
                    acc_d = acc_q + w_sample;
                    cnt_d = cnt_q + 5'd1;
                    gap_d = '0;
                    if (cnt_q == c_WIN_LAST) state_d = EMIT;
                end else if (gap_q != c_GAP_MAX) begin
                    gap_d = gap_q + 1'b1;
                    if (gap_q + 1'b1 == c_GAP_MAX) timeout_d = 1'b1;
                end
            end
            EMIT: begin
                avg_out_d   = w_res;
                avg_valid_d = 1'b1;
                if (w_sat_hi || w_sat_lo) ovr_d = 1'b1;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = bus.enable ? ACCUM : IDLE;
            end
            default: state_d = IDLE;
        endcase

        // clr wins; an EMIT in progress still publishes but cannot raise ovr
        if (bus.clr) begin
            acc_d     = '0;
            cnt_d     = '0;
            gap_d     = '0;
            ovr_d     = 1'b0;
            timeout_d = 1'b0;
        end
    end

    always_ff @(posedge clk_ref or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state_q     <= IDLE;
            dv_q        <= 1'b0;
            armed_q     <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            gap_q       <= '0;
            avg_valid_q <= 1'b0;
            avg_out_q   <= '0;
            ovr_q       <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            dv_q        <= bus.din_valid;
            armed_q     <= armed_q | ~bus.din_valid;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            avg_valid_q <= avg_valid_d;
            avg_out_q   <= avg_out_d;
            ovr_q       <= ovr_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.avg_valid = avg_valid_q;
    assign bus.avg_out   = avg_out_q;
    assign bus.ovr       = ovr_q;
    assign bus.timeout   = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_adc_sample_avg.sv
// ============================================================================
// Module : tb_adc_sample_avg
// Brief  : Directed self-checking bench for adc_sample_avg (AVG_LOG2=2, TIMEOUT_CYC=20).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_adc_sample_avg;

    logic clk_ref = 1'b0;
    logic sys_rstn;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_strobe = 0;
    int   n0;

    adc_sample_avg_if bus();

    adc_sample_avg #(
        .AVG_LOG2    (2),
        .TIMEOUT_CYC (20)
    ) dut (
        .clk_ref  (clk_ref),
        .sys_rstn (sys_rstn),
        .bus      (bus)
    );

    always #5 clk_ref = ~clk_ref;

    always @(negedge clk_ref) begin
        if (bus.avg_valid === 1'b1) n_strobe++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_ref);
        #1;
    endtask

    task automatic push(input logic [15:0] d);
        bus.din       = d;
        bus.din_valid = 1'b1;
        tick(1);
        bus.din_valid = 1'b0;
        tick(1);
    endtask

    // last sample of a window: strobe must appear exactly one cycle after acceptance
    task automatic push_last(input string tag, input logic [15:0] d, input logic [15:0] exp);
        bus.din       = d;
        bus.din_valid = 1'b1;
        tick(1);
        check({tag, "_early"}, {31'd0, bus.avg_valid}, 32'd0);
        bus.din_valid = 1'b0;
        tick(1);
        check({tag, "_vld"}, {31'd0, bus.avg_valid}, 32'd1);
        check({tag, "_out"}, {16'd0, bus.avg_out}, {16'd0, exp});
        tick(1);
        check({tag, "_one"}, {31'd0, bus.avg_valid}, 32'd0);
    endtask

    task automatic pulse_clr();
        bus.clr = 1'b1;
        tick(1);
        bus.clr = 1'b0;
    endtask

    initial begin
        sys_rstn      = 1'b0;
        bus.din_valid = 1'b0;
        bus.din       = 16'h0000;
        bus.enable    = 1'b0;
        bus.clr       = 1'b0;
        bus.offset    = 16'h0000;
        tick(3);
        check("rst_vld", {31'd0, bus.avg_valid}, 32'd0);
        check("rst_out", {16'd0, bus.avg_out}, 32'd0);
        check("rst_ovr", {31'd0, bus.ovr}, 32'd0);
        check("rst_tmo", {31'd0, bus.timeout}, 32'd0);
        sys_rstn = 1'b1;
        tick(1);

        // (4+4+8+8)/4 - 2 = 4
        bus.offset = 16'd2;
        bus.enable = 1'b1;
        tick(2);
        push(16'h8004);
        push(16'h8004);
        push(16'h8008);
        push_last("avg4", 16'h8008, 16'd4);
        check("avg4_ovr", {31'd0, bus.ovr}, 32'd0);

        // -32768 - 100 saturates low
        bus.offset = 16'd100;
        push(16'h0000);
        push(16'h0000);
        push(16'h0000);
        push_last("satlo", 16'h0000, 16'h8000);
        check("satlo_ovr", {31'd0, bus.ovr}, 32'd1);
        bus.offset = 16'd0;
        push(16'h8000);
        push(16'h8000);
        push(16'h8000);
        push_last("zero", 16'h8000, 16'h0000);
        check("ovr_sticky", {31'd0, bus.ovr}, 32'd1);
        pulse_clr();
        check("ovr_clr", {31'd0, bus.ovr}, 32'd0);

        // sum -1 floors to -1; -1 - (-5) = 4
        bus.offset = 16'hFFFB;
        push(16'h7FFF);
        push(16'h8000);
        push(16'h8000);
        push_last("floor", 16'h8000, 16'd4);

        // +32767 - (-32768) saturates high
        bus.offset = 16'h8000;
        push(16'hFFFF);
        push(16'hFFFF);
        push(16'hFFFF);
        push_last("sathi", 16'hFFFF, 16'h7FFF);
        check("sathi_ovr", {31'd0, bus.ovr}, 32'd1);
        pulse_clr();

        // long din_valid pulses: one sample each
        bus.offset = 16'd0;
        n0 = n_strobe;
        for (int i = 0; i < 4; i++) begin
            bus.din       = 16'h8010;
            bus.din_valid = 1'b1;
            tick(80);
            bus.din_valid = 1'b0;
            tick(2);
            if (i == 2) check("long_3", n_strobe - n0, 32'd0);
        end
        check("long_cnt", n_strobe - n0, 32'd1);
        check("long_out", {16'd0, bus.avg_out}, 32'd16);

        // partial window discarded by enable drop
        push(16'h8100);
        push(16'h8100);
        bus.enable = 1'b0;
        tick(2);
        bus.enable = 1'b1;
        tick(2);
        n0 = n_strobe;
        push(16'h8000);
        push(16'h8000);
        push(16'h8000);
        check("reen_3", n_strobe - n0, 32'd0);
        push_last("reen", 16'h8000, 16'h0000);

        // timeout on the 20th ACCUM cycle
        bus.enable = 1'b0;
        tick(2);
        pulse_clr();
        check("tmo_clr0", {31'd0, bus.timeout}, 32'd0);
        bus.enable = 1'b1;
        tick(1);
        tick(19);
        check("tmo_19", {31'd0, bus.timeout}, 32'd0);
        tick(1);
        check("tmo_20", {31'd0, bus.timeout}, 32'd1);
        pulse_clr();
        check("tmo_clr", {31'd0, bus.timeout}, 32'd0);

        // sample edge coincident with clr is dropped
        bus.din       = 16'h8400;
        bus.din_valid = 1'b1;
        bus.clr       = 1'b1;
        tick(1);
        bus.clr       = 1'b0;
        bus.din_valid = 1'b0;
        tick(1);
        n0 = n_strobe;
        push(16'h8020);
        push(16'h8020);
        push(16'h8020);
        check("clrdrop_3", n_strobe - n0, 32'd0);
        push_last("clrdrop", 16'h8020, 16'd32);

        // reset mid-window with din_valid held high across release
        push(16'h8400);
        push(16'h8400);
        bus.din       = 16'h8400;
        bus.din_valid = 1'b1;
        tick(1);
        sys_rstn = 1'b0;
        tick(2);
        check("rst2_out", {16'd0, bus.avg_out}, 32'd0);
        check("rst2_vld", {31'd0, bus.avg_valid}, 32'd0);
        sys_rstn = 1'b1;
        tick(3);
        bus.din_valid = 1'b0;
        tick(1);
        n0 = n_strobe;
        push(16'h8020);
        push(16'h8020);
        push(16'h8020);
        check("postrst_3", n_strobe - n0, 32'd0);
        push_last("postrst", 16'h8020, 16'd32);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
